// File: rtl/seq_divider_64.sv
// seq_divider_64: iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while busy==0
//   dividend   2*WIDTH-bit numerator, captured on the accepting edge
//   divisor    WIDTH-bit denominator, captured on the accepting edge
//   busy       iteration (or error cycle) in progress
//   done       one-cycle pulse, results valid from this cycle
//   quotient   registered quotient, held until the next done
//   remainder  registered remainder, held until the next done
//   dbz        divide-by-zero flag, valid with done
//   ovf        quotient-overflow flag, valid with done
module seq_divider_64 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 dbz,
    output logic                 ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [1:0]       r_state;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_sh;
    logic             w_ge;
    logic [WIDTH:0]   w_nrem;
    logic [WIDTH-1:0] w_nquo;
    // Partial remainder stays below the divisor, so after the shift it fits W+1 bits.
    always_comb begin
        w_sh   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_ge   = w_sh >= {1'b0, r_div};
        w_nrem = w_ge ? w_sh - {1'b0, r_div} : w_sh;
        w_nquo = {r_quo[WIDTH-2:0], w_ge};
    end
    assign busy = r_state != S_IDLE;
    // While in ERR, r_quo still holds dividend[W-1:0], which is the reported remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_div   <= divisor;
                    r_rem   <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                    r_quo   <= dividend[WIDTH-1:0];
                    r_cnt   <= '0;
                    r_state <= (divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor) ? S_ERR : S_RUN;
                end
            end else if (r_state == S_RUN) begin
                r_rem <= w_nrem;
                r_quo <= w_nquo;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    quotient  <= w_nquo;
                    remainder <= w_nrem[WIDTH-1:0];
                    done      <= 1'b1;
                    r_state   <= S_IDLE;
                end
            end else begin
                quotient  <= '1;
                remainder <= r_quo;
                dbz       <= r_div == '0;
                ovf       <= r_div != '0;
                done      <= 1'b1;
                r_state   <= S_IDLE;
            end
        end
    end
endmodule
